// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - four-digit multiplexed seven-segment scan scheduler with guard slot and PWM
// Optional leading-zero suppression is built when LEADING_ZERO_BLANK_EN is defined.
module sevseg_scan_ctrl #(
  parameter int PRESCALE = 50
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  brightness,
  input  logic        blank,
  output logic [7:0]  SEG,
  output logic [3:0]  DIGIT,
  output logic        frame_start
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_GUARD = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  slot_q, slot_d;
  logic        boot_q, boot_d;
  logic [15:0] snap_value_q, snap_value_d;
  logic [3:0]  snap_dp_q, snap_dp_d;
  logic [3:0]  snap_bright_q, snap_bright_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  digit_q, digit_d;
  logic        frame_start_q, frame_start_d;

  logic        tick;
  logic        latch;
  logic        suppress;
  logic [3:0]  cur_code;

  // Active-low segment pattern, bit 0 = a .. bit 6 = g; anything above 9 renders as a dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    boot_d        = 1'b0;
    snap_value_d  = snap_value_q;
    snap_dp_d     = snap_dp_q;
    snap_bright_d = snap_bright_q;

    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      case (state_q)
        ST_GUARD: begin
          state_d = ST_ON;
          slot_d  = 4'd0;
        end
        ST_ON: begin
          if (slot_q == snap_bright_q) begin
            slot_d = 4'd0;
            if (snap_bright_q == 4'hF) begin
              state_d = ST_GUARD;
              idx_d   = idx_q + 2'd1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        ST_OFF: begin
          if (slot_q == 4'd14 - snap_bright_q) begin
            slot_d  = 4'd0;
            state_d = ST_GUARD;
            idx_d   = idx_q + 2'd1;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_GUARD;
          slot_d  = 4'd0;
        end
      endcase
    end

    // A new frame begins on the boot cycle and on every fresh entry into digit 0 GUARD.
    latch = boot_q ||
            (tick && (state_q != ST_GUARD) && (state_d == ST_GUARD) && (idx_d == 2'd0));
    if (latch) begin
      snap_value_d  = value;
      snap_dp_d     = dp_mask;
      snap_bright_d = brightness;
    end
    frame_start_d = latch;

    case (idx_d)
      2'd0:    cur_code = snap_value_d[3:0];
      2'd1:    cur_code = snap_value_d[7:4];
      2'd2:    cur_code = snap_value_d[11:8];
      default: cur_code = snap_value_d[15:12];
    endcase

    suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd3:    suppress = (snap_value_d[15:12] == 4'd0);
      2'd2:    suppress = (snap_value_d[15:8] == 8'd0);
      2'd1:    suppress = (snap_value_d[15:4] == 12'd0);
      default: suppress = 1'b0;
    endcase
`else
    suppress = 1'b0;
`endif

    seg_d = {~snap_dp_d[idx_d], glyph(cur_code)};

    digit_d = 4'hF;
    if ((state_d == ST_ON) && !blank && !suppress) begin
      digit_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_GUARD;
      presc_q       <= '0;
      idx_q         <= 2'd0;
      slot_q        <= 4'd0;
      boot_q        <= 1'b1;
      snap_value_q  <= 16'h0000;
      snap_dp_q     <= 4'h0;
      snap_bright_q <= 4'h0;
      seg_q         <= 8'hFF;
      digit_q       <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      slot_q        <= slot_d;
      boot_q        <= boot_d;
      snap_value_q  <= snap_value_d;
      snap_dp_q     <= snap_dp_d;
      snap_bright_q <= snap_bright_d;
      seg_q         <= seg_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign SEG         = seg_q;
  assign DIGIT       = digit_q;
  assign frame_start = frame_start_q;

endmodule
